result_writer: RTL and testbench

//   Downstream stage of the matrix-vector engine: on start, snapshots the eight
//   24-bit results C[0..7] and writes them back to memory through an Avalon-MM

---
 rtl/matvec_pkg.sv | 21 ++
 rtl/result_writer_if.sv | 28 ++
 rtl/result_writer.sv | 102 ++++++++++
 tb/tb_result_writer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix-vector engine.
// Holds the result-writer state encoding and the 64-bit result packing function.
package matvec_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } wr_state_t;

    localparam int NUM_ROWS  = 8;
    localparam int RESULT_W  = 24;
    localparam int MM_DATA_W = 64;

    // Two results per bus word: lo in bits [31:0], hi in bits [63:32].
    function automatic logic [MM_DATA_W-1:0] pack_word(input logic [31:0] lo,
                                                       input logic [31:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/result_writer_if.sv
// Avalon-MM write-master bundle between the result writer and memory.
// Waitrequest is the only slave-driven signal; everything else comes from the master.
interface result_writer_if;
    import matvec_pkg::*;

    logic [31:0]          address;
    logic                 write;
    logic [MM_DATA_W-1:0] writedata;
    logic [7:0]           byteenable;
    logic                 waitrequest;

    modport master (
        output address,
        output write,
        output writedata,
        output byteenable,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  byteenable,
        output waitrequest
    );

endinterface

// File: rtl/result_writer.sv
// Purpose: snapshot NUM_RESULTS results on start and write them out as packed 64-bit Avalon-MM words.
// Latency: start at cycle 0 -> writes in cycles 1..NUM_RESULTS/2, done pulse the cycle after the last accept.
// Backpressure: mm waitrequest freezes address/data in place; each stalled cycle adds one cycle.
module result_writer #(
    parameter int          NUM_RESULTS = 8,
    parameter int          RESULT_W    = 24,
    parameter logic [31:0] BASE_ADDR   = 32'h100,
    parameter logic [31:0] ADDR_STRIDE = 32'd1,
    localparam int         CNT_W       = $clog2(NUM_RESULTS / 2 + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [RESULT_W-1:0] c_in [0:NUM_RESULTS-1],
    result_writer_if.master     mm,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    words_written
);

    localparam int NUM_WORDS = NUM_RESULTS / 2;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    matvec_pkg::wr_state_t state;
    logic [IDX_W-1:0]      idx;
    logic [RESULT_W-1:0]   cap [0:NUM_RESULTS-1];

    logic [IDX_W-1:0]                 nxt_idx;
    logic [IDX_W:0]                   sel_lo;
    logic [IDX_W:0]                   sel_hi;
    logic [matvec_pkg::MM_DATA_W-1:0] first_word;
    logic [matvec_pkg::MM_DATA_W-1:0] nxt_word;

    // The following word is pre-computed so an accepted write can be replaced without a bubble.
    always_comb begin
        nxt_idx    = idx + 1'b1;
        sel_lo     = {nxt_idx, 1'b0};
        sel_hi     = {nxt_idx, 1'b1};
        first_word = matvec_pkg::pack_word(32'(c_in[0]), 32'(c_in[1]));
        nxt_word   = matvec_pkg::pack_word(32'(cap[sel_lo]), 32'(cap[sel_hi]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= matvec_pkg::S_IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            mm.address    <= '0;
            mm.write      <= 1'b0;
            mm.writedata  <= '0;
            mm.byteenable <= '0;
            for (int i = 0; i < NUM_RESULTS; i++) begin
                cap[i] <= '0;
            end
        end else begin
            case (state)
                matvec_pkg::S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cap           <= c_in;
                        idx           <= '0;
                        words_written <= '0;
                        busy          <= 1'b1;
                        mm.write      <= 1'b1;
                        mm.address    <= BASE_ADDR;
                        mm.writedata  <= first_word;
                        mm.byteenable <= 8'hFF;
                        state         <= matvec_pkg::S_WRITE;
                    end
                end
                matvec_pkg::S_WRITE: begin
                    if (!mm.waitrequest) begin
                        words_written <= words_written + 1'b1;
                        if (idx == LAST_IDX) begin
                            mm.write      <= 1'b0;
                            mm.byteenable <= 8'h00;
                            done          <= 1'b1;
                            state         <= matvec_pkg::S_DONE;
                        end else begin
                            idx          <= nxt_idx;
                            mm.address   <= mm.address + ADDR_STRIDE;
                            mm.writedata <= nxt_word;
                        end
                    end
                end
                matvec_pkg::S_DONE: begin
                    // start is deliberately not looked at here.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= matvec_pkg::S_IDLE;
                end
                default: begin
                    state <= matvec_pkg::S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: stimulus queues expected writes and done cycles,
// a negedge monitor pops and compares every accepted write and every done pulse.
module tb_result_writer;

    typedef logic [23:0] vec_t [8];
    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] c_in [8];
    logic        busy;
    logic        done;
    logic [2:0]  words_written;

    result_writer_if mm();

    result_writer #(
        .NUM_RESULTS (8),
        .RESULT_W    (24),
        .BASE_ADDR   (32'h100),
        .ADDR_STRIDE (32'd1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .c_in          (c_in),
        .mm            (mm),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t exp_q[$];
    int  done_q[$];
    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    int  last_acc = 0;
    int  a101_cycles = 0;
    int  wmode = 0;
    int  stall_left = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Waitrequest driver: 0 none, 1 three stalls on 0x101, 2 random, 3 stall forever on 0x102.
    initial begin
        mm.waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (wmode)
                1: begin
                    if (mm.write && mm.address == 32'h101 && stall_left > 0) begin
                        mm.waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        mm.waitrequest = 1'b0;
                    end
                end
                2: mm.waitrequest = 1'($urandom_range(0, 1));
                3: mm.waitrequest = mm.write && (mm.address == 32'h102);
                default: mm.waitrequest = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        automatic logic        prev_stall = 1'b0;
        automatic logic        prev_done = 1'b0;
        automatic logic [31:0] prev_addr = '0;
        automatic logic [63:0] prev_data = '0;
        automatic wr_t         e;
        automatic int          d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_write", mm.write, 1);
                    chk("hold_addr", mm.address, prev_addr);
                    chk("hold_data", mm.writedata, prev_data);
                end
                if (mm.write && mm.address == 32'h101) a101_cycles++;
                if (mm.write) begin
                    chk("byteenable_write", mm.byteenable, 8'hFF);
                    chk("busy_during_write", busy, 1);
                    if (!mm.waitrequest) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: addr %h data %h, no write expected", mm.address, mm.writedata);
                        end else begin
                            e = exp_q.pop_front();
                            chk("write_addr", mm.address, e.addr);
                            chk("write_data", mm.writedata, e.data);
                        end
                        last_acc = cyc;
                    end
                end else begin
                    chk("byteenable_idle", mm.byteenable, 8'h00);
                end
                if (prev_done) chk("busy_after_done", busy, 0);
                if (done) begin
                    done_cnt++;
                    chk("done_after_last_write", cyc, last_acc + 1);
                    chk("done_single_cycle", prev_done, 0);
                    chk("done_busy", busy, 1);
                    chk("done_words_written", words_written, 4);
                    if (done_q.size() > 0) begin
                        d = done_q.pop_front();
                        chk("done_cycle", cyc, d);
                    end
                end
                prev_stall = mm.write && mm.waitrequest;
                prev_addr  = mm.address;
                prev_data  = mm.writedata;
                prev_done  = done;
            end
        end
    end

    task automatic push_word(input logic [31:0] addr, input logic [23:0] lo, input logic [23:0] hi);
        wr_t w;
        w.addr = addr;
        w.data = {8'h00, hi, 8'h00, lo};
        exp_q.push_back(w);
    endtask

    task automatic push_run(input vec_t v);
        push_word(32'h100, v[0], v[1]);
        push_word(32'h101, v[2], v[3]);
        push_word(32'h102, v[4], v[5]);
        push_word(32'h103, v[6], v[7]);
    endtask

    task automatic wait_done(input int budget);
        int tgt;
        int n;
        tgt = done_cnt + 1;
        n = 0;
        while (done_cnt < tgt && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < tgt) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done within %0d cycles, count %0d required %0d", budget, done_cnt, tgt);
        end
    endtask

    task automatic wait_addr(input logic [31:0] addr, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(mm.write && mm.address == addr) && n < budget);
        if (!(mm.write && mm.address == addr)) begin
            checks++;
            errors++;
            $display("FAIL wait_addr: address %h never presented, last %h", addr, mm.address);
        end
    endtask

    // exp_lat < 0 means the absolute done cycle is not predicted.
    task automatic run(input vec_t v, input int mode, input int exp_lat);
        int t0;
        wmode = mode;
        stall_left = 3;
        c_in = v;
        push_run(v);
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        if (exp_lat >= 0) done_q.push_back(t0 + exp_lat);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(300);
    endtask

    vec_t v1, v2, vff, v3, v4, vr;

    initial begin
        int t0;
        int n;
        int dbefore;
        for (int i = 0; i < 8; i++) begin
            v1[i] = 24'(i + 1);
            v2[i] = 24'h00A000 + 24'(i);
            vff[i] = 24'hFFFFFF;
            v3[i] = 24'h123400 + 24'(i * 17);
            v4[i] = 24'h800000 | 24'(i * 3);
            c_in[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", mm.write, 0);
        chk("rst_address", mm.address, 0);
        chk("rst_writedata", mm.writedata, 0);
        chk("rst_byteenable", mm.byteenable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words_written", words_written, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: counting data, no stalls, done at t0+5
        run(v1, 0, 5);
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_words_hold", words_written, 4);

        // 2: three stalls on word 1, done at t0+8
        a101_cycles = 0;
        run(v1, 1, 8);
        chk("stall_0x101_cycles", a101_cycles, 4);
        @(posedge clk);
        #1;
        chk("stall_words_written", words_written, 4);

        // 3: all-ones results stay zero-extended
        run(vff, 0, 5);

        // 4: second start and new c_in during word 2 are ignored
        wmode = 0;
        c_in = v1;
        push_run(v1);
        dbefore = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        done_q.push_back(t0 + 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_addr(32'h102, 20);
        start = 1'b1;
        c_in = v2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(50);
        repeat (10) @(posedge clk);
        chk("single_done_pulse", done_cnt, dbefore + 1);
        chk("no_extra_writes", exp_q.size(), 0);

        // start held across the done cycle: ignored in done, accepted the cycle after
        c_in = v3;
        push_run(v3);
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        done_q.push_back(t0 + 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b1;
        c_in = v4;
        push_run(v4);
        @(posedge clk);
        #1;
        t0 = cyc;
        done_q.push_back(t0 + 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(50);

        // 5: reset while word 2 is stalled
        wmode = 3;
        c_in = v2;
        push_run(v2);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_addr(32'h102, 20);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_write", mm.write, 0);
        chk("arst_busy", busy, 0);
        chk("arst_address", mm.address, 0);
        chk("arst_words_written", words_written, 0);
        chk("arst_pending_words", exp_q.size(), 2);
        exp_q.delete();
        wmode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(v3, 0, 5);

        // 6: random data, random waitrequest
        for (int r = 0; r < 100; r++) begin
            for (int i = 0; i < 8; i++) vr[i] = 24'($urandom());
            run(vr, 2, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wmode = 0;
        repeat (5) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_done_queue_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d errors", errors);
        $fatal(1, "watchdog");
    end

endmodule
